// File: rtl/sdram_arbit.sv
`timescale 1ns/1ps
// SDRAM command-bus scheduler: init owns the bus first, then refresh > write > read (round-robin write/read tie under SDRAM_RW_RR_EN).
// Grants are registered, one arbitration cycle per decision; grants are held until *_end or forced release after TIMEOUT_CYC cycles.
module sdram_arbit #(
  parameter int ADDR_W      = 12,
  parameter int BANK_W      = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_end,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              rd_en,
  output logic              err_timeout,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [3:0]       CMD_NOP  = 4'b0111;

  typedef enum logic [2:0] {S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              aref_en_q, aref_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              err_q, err_d;
  logic              grant_end;
  logic              in_grant;
`ifdef SDRAM_RW_RR_EN
  logic              last_rw_q, last_rw_d;  // 1: write was served last
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    grant_end = 1'b0;
    in_grant  = 1'b0;
`ifdef SDRAM_RW_RR_EN
    last_rw_d = last_rw_q;
`endif
    case (state_q)
      S_INIT:  if (init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (aref_req) state_d = S_AREF;
`ifdef SDRAM_RW_RR_EN
        else if (wr_req && rd_req) state_d = last_rw_q ? S_READ : S_WRITE;
`endif
        else if (wr_req) state_d = S_WRITE;
        else if (rd_req) state_d = S_READ;
      end
      S_AREF:  begin in_grant = 1'b1; grant_end = aref_end; end
      S_WRITE: begin in_grant = 1'b1; grant_end = wr_end;   end
      S_READ:  begin in_grant = 1'b1; grant_end = rd_end;   end
      default: state_d = S_INIT;
    endcase

    // A real end in the timeout cycle wins, so no error is flagged then.
    if (in_grant) begin
      if (grant_end) begin
        state_d = S_ARBIT;
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_ARBIT;
        err_d   = 1'b1;
      end
    end

    if (state_d != state_q)                 cnt_d = '0;
    else if (in_grant && cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);

`ifdef SDRAM_RW_RR_EN
    if (state_q == S_ARBIT && state_d == S_WRITE) last_rw_d = 1'b1;
    if (state_q == S_ARBIT && state_d == S_READ)  last_rw_d = 1'b0;
`endif

    aref_en_d = (state_d == S_AREF);
    wr_en_d   = (state_d == S_WRITE);
    rd_en_d   = (state_d == S_READ);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef SDRAM_RW_RR_EN
      last_rw_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
`ifdef SDRAM_RW_RR_EN
      last_rw_q <= last_rw_d;
`endif
    end
  end

  logic [3:0]        cmd_mux;
  logic [BANK_W-1:0] bank_mux;
  logic [ADDR_W-1:0] addr_mux;

  always_comb begin
    cmd_mux  = CMD_NOP;
    bank_mux = '0;
    addr_mux = '0;
    case (state_q)
      S_INIT:  begin cmd_mux = init_cmd; addr_mux = init_addr; end
      S_AREF:  begin cmd_mux = aref_cmd; addr_mux = aref_addr; end
      S_WRITE: begin cmd_mux = wr_cmd; bank_mux = wr_bank; addr_mux = wr_addr; end
      S_READ:  begin cmd_mux = rd_cmd; bank_mux = rd_bank; addr_mux = rd_addr; end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_bank  = bank_mux;
  assign sdram_addr  = addr_mux;
  assign sdram_cke   = 1'b1;
  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sdram_arbit.sv
`timescale 1ns/1ps
// Bench for sdram_arbit: directed vector table, multi-cycle corner sequences and a randomized run against a cycle model.
module tb_sdram_arbit;

  localparam int AW = 12;
  localparam int BW = 2;
  localparam int TO = 15;
`ifdef SDRAM_RW_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int M_INIT = 0, M_ARB = 1, M_AREF = 2, M_WR = 3, M_RD = 4;

  logic          sclk = 1'b0;
  logic          s_rst_n;
  logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [AW-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [BW-1:0] wr_bank, rd_bank;
  logic          init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic          aref_en, wr_en, rd_en, err_timeout, sdram_cke;
  logic          sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BW-1:0] sdram_bank;
  logic [AW-1:0] sdram_addr;

  always #5 sclk = ~sclk;

  sdram_arbit #(.ADDR_W(AW), .BANK_W(BW), .TIMEOUT_CYC(TO)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_end(aref_end), .aref_en(aref_en),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_end(wr_end), .wr_en(wr_en),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_end(rd_end), .rd_en(rd_en),
    .err_timeout(err_timeout), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, how long it has held it, who was served last.
  int m_st;
  int m_held;
  bit m_last_wr;
  bit m_err;

  typedef struct {
    logic [5:0] in;   // {aref_req, wr_req, rd_req, aref_end, wr_end, rd_end}
    logic [3:0] exp;  // {aref_en, wr_en, rd_en, err_timeout} seen in that cycle
  } vec_t;
  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_INIT; m_held = 0; m_last_wr = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    int nxt;
    bit ended;
    m_err = 1'b0;
    case (m_st)
      M_INIT: if (init_end) m_st = M_ARB;
      M_ARB: begin
        nxt = M_ARB;
        if (aref_req)              nxt = M_AREF;
        else if (wr_req && rd_req) nxt = (RR && m_last_wr) ? M_RD : M_WR;
        else if (wr_req)           nxt = M_WR;
        else if (rd_req)           nxt = M_RD;
        if (nxt == M_WR) m_last_wr = 1'b1;
        if (nxt == M_RD) m_last_wr = 1'b0;
        m_held = 0;
        m_st   = nxt;
      end
      default: begin
        m_held++;
        ended = (m_st == M_AREF && aref_end) || (m_st == M_WR && wr_end) || (m_st == M_RD && rd_end);
        if (ended) m_st = M_ARB;
        else if (m_held >= TO) begin m_st = M_ARB; m_err = 1'b1; end
      end
    endcase
  endtask

  function automatic logic [22:0] model_obs();
    logic [3:0] c; logic [BW-1:0] b; logic [AW-1:0] a;
    c = 4'b0111; b = '0; a = '0;
    case (m_st)
      M_INIT: begin c = init_cmd; a = init_addr; end
      M_AREF: begin c = aref_cmd; a = aref_addr; end
      M_WR:   begin c = wr_cmd; b = wr_bank; a = wr_addr; end
      M_RD:   begin c = rd_cmd; b = rd_bank; a = rd_addr; end
      default: ;
    endcase
    return {m_st == M_AREF, m_st == M_WR, m_st == M_RD, m_err, 1'b1, c, b, a};
  endfunction

  function automatic logic [22:0] dut_obs();
    return {aref_en, wr_en, rd_en, err_timeout, sdram_cke,
            sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr};
  endfunction

  task automatic drive(input logic ie, input logic [5:0] in);
    init_end = ie;
    {aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = in;
    init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
    init_addr = AW'($urandom); aref_addr = AW'($urandom); wr_addr = AW'($urandom); rd_addr = AW'($urandom);
    wr_bank = BW'($urandom); rd_bank = BW'($urandom);
  endtask

  // Compare against the model, then advance both across one clock edge.
  task automatic cyc();
    #1;
    check("model_outputs", 32'(dut_obs()), 32'(model_obs()));
    @(posedge sclk);
    model_edge();
    #1;
  endtask

  initial begin
    int seen_grant, n_rd, n_wr, n_err, err_at, last_rd, g_cnt;
    int order[$];
    logic prev_w, prev_r;

    tbl[0]  = '{6'b111000, 4'b0000};
    tbl[1]  = '{6'b011000, 4'b1000};
    tbl[2]  = '{6'b011100, 4'b1000};
    tbl[3]  = '{6'b011000, 4'b0000};
    tbl[4]  = '{6'b001000, 4'b0100};
    tbl[5]  = '{6'b001010, 4'b0100};
    tbl[6]  = '{6'b001000, 4'b0000};
    tbl[7]  = '{6'b000000, 4'b0010};
    tbl[8]  = '{6'b000001, 4'b0010};
    tbl[9]  = '{6'b000000, 4'b0000};
    tbl[10] = '{6'b010000, 4'b0000};
    tbl[11] = '{6'b000000, 4'b0100};
    tbl[12] = '{6'b000010, 4'b0100};
    tbl[13] = '{6'b000000, 4'b0000};
    tbl[14] = '{6'b010000, 4'b0000};
    tbl[15] = '{6'b100000, 4'b0100};
    tbl[16] = '{6'b100000, 4'b0100};
    tbl[17] = '{6'b100010, 4'b0100};
    tbl[18] = '{6'b100000, 4'b0000};
    tbl[19] = '{6'b000011, 4'b1000};
    tbl[20] = '{6'b000100, 4'b1000};
    tbl[21] = '{6'b000000, 4'b0000};

    s_rst_n = 1'b0;
    model_reset();
    drive(1'b0, 6'b000000);
    @(posedge sclk);
    #1;
    check("reset_grants_err", {aref_en, wr_en, rd_en, err_timeout}, 4'b0000);
    check("reset_cke", sdram_cke, 1'b1);
    check("reset_pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr},
          {init_cmd, 2'b00, init_addr});
    s_rst_n = 1'b1;

    // Init phase: requests pile up from cycle 3 and must wait for init_end at cycle 20.
    seen_grant = 0;
    for (int c = 1; c <= 20; c++) begin
      drive(c == 20, (c >= 3) ? 6'b111000 : 6'b000000);
      if (aref_en || wr_en || rd_en) seen_grant++;
      if (c == 20) begin
        #1;
        check("init_pins_c20", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr},
              {init_cmd, 2'b00, init_addr});
      end
      cyc();
    end
    check("no_grant_in_init", seen_grant, 0);
    check("nop_after_init", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr}, 18'h1C000);

    for (int i = 0; i < 22; i++) begin
      drive(1'b0, tbl[i].in);
      #1;
      check($sformatf("vec%0d", i), {aref_en, wr_en, rd_en, err_timeout}, tbl[i].exp);
      cyc();
    end

    // Read held without rd_end: forced release after TO cycles.
    drive(1'b0, 6'b001000);
    cyc();
    n_rd = 0; n_err = 0; err_at = -1; last_rd = -1;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 6'b000000);
      if (rd_en) begin n_rd++; last_rd = k; end
      if (err_timeout) begin n_err++; err_at = k; end
      cyc();
    end
    check("timeout_rd_cycles", n_rd, TO);
    check("timeout_err_pulses", n_err, 1);
    check("timeout_err_position", err_at, last_rd + 1);

    // Write and read both held high: record the order of the first three grants.
    g_cnt = 0; prev_w = 1'b0; prev_r = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (order.size() >= 3 && !wr_en && !rd_en) break;
      if (wr_en && !prev_w) order.push_back(1);
      if (rd_en && !prev_r) order.push_back(2);
      prev_w = wr_en; prev_r = rd_en;
      g_cnt = (wr_en || rd_en) ? g_cnt + 1 : 0;
      drive(1'b0, {1'b0, 1'b1, 1'b1, 1'b0, wr_en && g_cnt == 2, rd_en && g_cnt == 2});
      cyc();
    end
    check("rr_grant_count", order.size(), 3);
    while (order.size() < 3) order.push_back(0);
    check("rr_grant0", order[0], 1);
    check("rr_grant1", order[1], RR ? 2 : 1);
    check("rr_grant2", order[2], 1);

    // wr_end in the very cycle the timeout would fire: normal end, no error.
    drive(1'b0, 6'b010000);
    cyc();
    n_wr = 0; n_err = 0;
    for (int k = 0; k < 24; k++) begin
      if (wr_en) n_wr++;
      if (err_timeout) n_err++;
      drive(1'b0, {4'b0000, wr_en && n_wr == TO, 1'b0});
      cyc();
    end
    check("end_at_timeout_wr_cycles", n_wr, TO);
    check("end_at_timeout_no_err", n_err, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 4000; k++) begin
      drive(($urandom % 8) == 0,
            {1'($urandom % 3 == 0), 1'($urandom), 1'($urandom),
             1'($urandom % 5 == 0), 1'($urandom % 5 == 0), 1'($urandom % 5 == 0)});
      if ($urandom % 400 == 0) begin
        s_rst_n = 1'b0;
        #1;
        check("async_reset_grants", {aref_en, wr_en, rd_en, err_timeout}, 4'b0000);
        model_reset();
        #1;
        s_rst_n = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Central scheduler for the single SDRAM command bus.
- Owns the bus during power-up init, then grants it to one of three requesters: auto-refresh, write burst, read burst.
- Muxes the granted requester's command, bank and address onto the SDRAM pins.
- Sits inside the SDRAM top, between the UART-fed command path and the sdram_* pins.

Parameters:
- ADDR_W, 12, SDRAM address bus width
- BANK_W, 2, bank address width
- TIMEOUT_CYC, 1023, max cycles any grant may be held before forced release

Ports:
- sclk  in  1  system clock (50 MHz)
- s_rst_n  in  1  asynchronous active-low reset
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_addr  in  ADDR_W  init address (mode register value)
- init_end  in  1  one-cycle pulse, init sequence done
- aref_req  in  1  refresh request, level, held until granted
- aref_cmd  in  4  refresh command
- aref_addr  in  ADDR_W  refresh address (A10 for precharge-all)
- aref_end  in  1  one-cycle pulse, refresh done
- aref_en  out  1  refresh grant
- wr_req  in  1  write request, level
- wr_cmd  in  4  write command
- wr_bank  in  BANK_W  write bank
- wr_addr  in  ADDR_W  write address
- wr_end  in  1  one-cycle pulse, write burst done
- wr_en  out  1  write grant
- rd_req  in  1  read request, level
- rd_cmd  in  4  read command
- rd_bank  in  BANK_W  read bank
- rd_addr  in  ADDR_W  read address
- rd_end  in  1  one-cycle pulse, read burst done
- rd_en  out  1  read grant
- err_timeout  out  1  one-cycle pulse, grant forcibly revoked
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_bank  out  BANK_W  bank pins
- sdram_addr  out  ADDR_W  address pins

Behaviour:
- Clock and reset: one clock, sclk. s_rst_n is asynchronous and active-low.
- Reset values:
  - state = INIT
  - aref_en, wr_en, rd_en = 0
  - err_timeout = 0
  - timeout counter = 0
  - sdram_cke = 1 (constant after reset)
- States: INIT, ARBIT, AREF, WRITE, READ. State is registered.
- INIT:
  - Pins driven from init_cmd / init_addr; bank = 0.
  - init_end -> ARBIT. All other requests ignored.
- ARBIT:
  - Pins = NOP (4'b0111), bank 0, addr 0.
  - Priority: aref_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay.
  - A decision takes exactly one cycle in ARBIT.
- AREF / WRITE / READ:
  - Pins driven from the matching requester's cmd/bank/addr; aref bank = 0.
  - Matching *_end -> ARBIT.
  - Non-matching *_end pulses are ignored.
  - No preemption: a refresh request during WRITE/READ waits. The write/read modules watch aref_req themselves and end their burst early.
- Grants:
  - aref_en / wr_en / rd_en are registered.
  - Set on the edge that enters the state; cleared on the edge that leaves it.
  - A grant is high exactly while in its state, so exactly one cycle after the req was sampled in ARBIT.
  - At most one grant high at any time.
- Pin mux: combinational from the registered state plus requester inputs. Requesters must drive their cmd as registers.
- Timeout:
  - Counter clears on every state change and increments while in AREF/WRITE/READ.
  - At TIMEOUT_CYC without *_end: go to ARBIT, drop the grant, pulse err_timeout for 1 cycle.
  - The counter saturates; there is no wrap.
- Simultaneous events:
  - *_end and timeout in the same cycle: treated as a normal end, no err_timeout.
  - Requests arriving while in INIT are held by their requesters and served in priority order after init.
- Reset mid-operation: immediate return to INIT, grants drop asynchronously, pins go to NOP via the init module's reset output.

Optional Feature:
- Macro: SDRAM_RW_RR_EN.
- Defined:
  - When wr_req and rd_req are both high in ARBIT (no aref_req), grant alternates.
  - A last_rw flag (reset = read-served) makes write win the first tie.
  - The flag is updated on each WRITE/READ entry.
  - Refresh still has top priority.
- Undefined: write always beats read (fixed priority); no last_rw register.

Test Plan:
- Reset release, init_end pulse at cycle 20:
  - pins follow init_cmd until cycle 20, NOP at cycle 21;
  - no grant before init_end.
- In ARBIT, raise wr_req:
  - wr_en high on the next edge; pins = wr_cmd/wr_bank/wr_addr;
  - wr_end pulse -> wr_en low next edge, NOP.
- aref_req, wr_req, rd_req all high in ARBIT:
  - grant order aref, write, read;
  - each separated by exactly one NOP cycle in ARBIT.
- aref_req raised during WRITE:
  - wr_en stays high until wr_end;
  - aref_en asserts 2 cycles after wr_end (ARBIT + grant edge).
- Hold READ without rd_end, TIMEOUT_CYC=15:
  - rd_en drops after 15 cycles in READ;
  - err_timeout pulses once; state returns to ARBIT.
- With SDRAM_RW_RR_EN, wr_req and rd_req held high continuously:
  - grants alternate write, read, write;
  - without the macro: write, write, write.
